// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg
// Shared definitions for the four-way round-robin mux arbiter:
//   - NUM_REQ / IDX_W : requester count and the width of a requester index
//   - state_t         : arbiter FSM encoding (IDLE=0, GRANT=1)
//   - oneHot()        : turns a requester index into a one-hot grant vector
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Grant vector with only the bit of the chosen requester set.
  function automatic logic [NUM_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if
// Bundles the requester-side and downstream-side signals of the arbiter.
//   req[3:0]        request/valid per requester
//   last[3:0]       final-beat marker per requester
//   data_in[4*DW]   requester i's data on [i*DW +: DW]
//   out_ready       downstream accepts the current beat
//   gnt[3:0]        one-hot grant (zero when idle)
//   sel[1:0]        mux select, index of the granted requester
//   out_valid       a beat is present on out_data
//   out_data[DW]    selected requester's data
// The master modport is the side that drives requests and readiness;
// the slave modport is the arbiter itself.
interface mux4_rr_arbiter_if #(
  parameter int DW = 8
);
  import mux4_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    last;
  logic [NUM_REQ*DW-1:0] data_in;
  logic                  out_ready;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      sel;
  logic                  out_valid;
  logic [DW-1:0]         out_data;

  modport master (
    output req, last, data_in, out_ready,
    input  gnt, sel, out_valid, out_data
  );

  modport slave (
    input  req, last, data_in, out_ready,
    output gnt, sel, out_valid, out_data
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4
// Combinational rotating-priority picker. Starting at index ptr and
// walking ptr+1, ptr+2, ptr+3 (mod 4), it returns the first requester
// whose req bit is set.
//   req[3:0]  in   request vector
//   ptr[1:0]  in   index that currently has the highest priority
//   found     out  at least one request is set
//   idx[1:0]  out  index of the chosen requester (equals ptr when none)
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk the rotated order from the farthest offset back to ptr itself,
  // so the closest set request is the last one written and wins. The
  // 2-bit addition gives the mod-4 wrap for free.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter that shares one DW-bit output channel between four
// requesters by steering the select of a 4:1 mux. A requester keeps its
// grant for one burst, ended by its last flag, by MAX_BURST beats, or by
// dropping its request; priority then rotates to the next index.
//   clk   in  clock, all state changes on the rising edge
//   rst   in  synchronous active-high reset
//   bus   slave side of mux4_rr_arbiter_if (req/last/data_in/out_ready in,
//         gnt/sel/out_valid/out_data out)
// Parameters: DW = data width per requester, MAX_BURST = beats per grant (>=1).
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4_rr_arbiter_if.slave     bus
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  state_t             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   sel_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [BW-1:0]      beats_q;

  logic               pickFound;
  logic [IDX_W-1:0]   pickIdx;

  logic               ownerReq;
  logic               ownerLast;
  logic               outValid;
  logic               transfer;
  logic [BW-1:0]      beats_d;
  logic               burstFull;
  logic               releaseNow;

  // Chooses the next owner from the live requests whenever we sit in IDLE.
  rr_pick4 uPick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pickFound),
    .idx   (pickIdx)
  );

  // Per-cycle view of the current owner: whether it still requests, whether
  // a beat moves this cycle, and whether this cycle ends its grant. Dropping
  // the request releases immediately even when no beat moves; a final beat
  // that both carries last and fills the burst is still a single release.
  always_comb begin
    ownerReq   = bus.req[owner_q];
    ownerLast  = bus.last[owner_q];
    outValid   = (state_q == GRANT) && ownerReq;
    transfer   = outValid && bus.out_ready;
    beats_d    = beats_q + BW'(1);
    burstFull  = (beats_d == BW'(MAX_BURST));
    releaseNow = (state_q == GRANT) &&
                 (!ownerReq || (transfer && (ownerLast || burstFull)));
  end

  // The data path is purely combinational off the registered select, so a
  // beat reaches the output in the same cycle the requester presents it.
  // sel keeps its previous value through IDLE, so out_data keeps pointing at
  // the last owner (requester 0 right after reset).
  assign bus.out_valid = outValid;
  assign bus.out_data  = bus.data_in[sel_q*DW +: DW];
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;

  // Arbiter FSM. IDLE loads a new owner from the picker and raises its grant
  // on the next edge, which is what leaves one bubble cycle between grants.
  // GRANT counts accepted beats and, on release, drops the grant and hands
  // top priority to the index after the owner. A stalled beat
  // (out_ready low) changes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      beats_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickFound) begin
            owner_q <= pickIdx;
            sel_q   <= pickIdx;
            gnt_q   <= oneHot(pickIdx);
            beats_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (releaseNow) begin
            ptr_q   <= owner_q + IDX_W'(1);
            gnt_q   <= '0;
            state_q <= IDLE;
          end else if (transfer) begin
            beats_q <= beats_d;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares a single DW-bit output channel between four requesters by sequencing the select of a 4:1 multiplexer. It sits in front of the shared mux datapath. It grants one requester at a time and holds the grant for a burst, ended by `last` or by a burst limit. It then rotates priority so that every active requester is served within four grant periods.

## Interface
Parameters:
- `DW`, 8: data width per requester.
- `MAX_BURST`, 4: maximum beats per grant; legal range ≥1.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `req`  in  4: request/valid per requester, bit i = requester i.
- `last`  in  4: bit i marks the final beat of requester i's packet; sampled only on a transfer.
- `data_in`  in  4*DW: requester i's data on bits [i*DW +: DW].
- `out_ready`  in  1: downstream accepts a beat this cycle.
- `gnt`  out  4: one-hot grant; all zero when idle.
- `sel`  out  2: mux select = index of granted requester.
- `out_valid`  out  1: beat present on `out_data`.
- `out_data`  out  DW: `data_in` slice selected by `sel`.

## Operation
- States: IDLE, GRANT. Registers: `state`, `owner[1:0]`, `ptr[1:0]` (highest-priority index), `beats` (width clog2(MAX_BURST)+1).
- IDLE, no `req`: stay in IDLE.
- IDLE, any `req`: pick the first set bit scanning `ptr`, `ptr+1`, … (mod 4).
  - Load `owner`; set `gnt` one-hot; set `sel=owner`; clear `beats`.
  - Go to GRANT.
- GRANT:
  - `out_valid = req[owner]`.
  - `out_data = data_in[owner*DW +: DW]`, combinational from `sel`.
  - Transfer occurs when `out_valid && out_ready`; each transfer increments `beats`.
- Release from GRANT (any one of the following):
  - a transfer with `last[owner]=1`;
  - a transfer that makes `beats == MAX_BURST`;
  - `req[owner]=0` in any GRANT cycle (requester abandoned; no transfer counted).
- On release: `ptr <= owner+1` (wraps 3→0), `gnt <= 0`, go to IDLE.
- `sel` holds its last value in IDLE.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle; no preemption.
- Stalls (`out_ready=0`) hold all state; `beats` does not advance.
- `req` changes on non-owner lines never affect `out_valid`.

## Timing
- Reset values: `state`=IDLE, `gnt`=0, `sel`=0, `ptr`=0, `owner`=0, `beats`=0, `out_valid`=0. `out_data` follows `data_in[DW-1:0]`.
- Grant latency: `req` seen in IDLE at edge N gives `gnt`/`sel` valid after edge N, so the first beat can transfer in cycle N+1.
- One mandatory IDLE bubble between consecutive grants. Back-to-back packets each cost (beats + 1) cycles.
- `out_valid` and `out_data` are combinational from registered `owner`/`state` and the current `req`/`data_in`; no registered data path, zero data latency.
- `gnt` and `sel` are registered and change only on clock edges.
- If `rst` is asserted mid-burst, all registers take reset values on that edge and the burst is dropped. `ptr` returns to 0.
- Simultaneous `last[owner]` and `beats` reaching `MAX_BURST`: a single release; `ptr` advances once.
- `MAX_BURST=1`: release after every transfer, giving strict alternation among active requesters.

## Structure
- Shared package/header: state encodings (IDLE=0, GRANT=1) and the requester count constant (4).
- One natural sub-module, `rr_pick4`: combinational rotate-priority picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `found`, `idx[1:0]`.
- The top level holds the FSM, counter, pointer and output slice select.
- Target: roughly 150–250 lines of RTL.

## Test plan
- Reset, then hold `req=4'b0000` for 5 cycles → `gnt=0`, `out_valid=0`, `sel=0` throughout.
- `req=4'b1111`, `last` set on every beat, `out_ready=1` → grants in order 0, 1, 2, 3, 0, each one beat, with one idle cycle between grants.
- `MAX_BURST=4`, requester 2 alone with `last=0` for 10 beats → bursts of 4, 4, 2 on `out_data=data_in[2]`, with `gnt=4'b0100` re-granted after each bubble.
- Owner 1 mid-burst, `out_ready=0` for 3 cycles → `beats`, `gnt` and `out_data` are held; no transfer is counted; the burst completes after `out_ready` returns.
- Owner 3 drops `req` after 2 beats while `req[0]=1` → release, `ptr` wraps to 0, and requester 0 is granted after one IDLE cycle.
- `rst` asserted during owner 2's second beat → next cycle `gnt=0`, `ptr=0`. With `req=4'b0110`, requester 1 is granted first.
